// File: rtl/vmac_exec_unit.sv
// Execute-stage unit for the packed-SIMD VMAC extension.
// Processes one lane per cycle through a single shared signed multiplier.
module vmac_exec_unit #(
    parameter int unsigned LANE_W    = 8,
    parameter int unsigned NUM_LANES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  vmac_ctrl,
    input  logic [4:0]  rd_in,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [31:0] acc_data,
    input  logic        flush,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [4:0]  rd_out,
    output logic        wb_en
);

    localparam int unsigned CNT_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(NUM_LANES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        OP_PVADD       = 2'b00,
        OP_PVMUL       = 2'b01,
        OP_PVMAC       = 2'b10,
        OP_PVMUL_UPPER = 2'b11
    } op_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        a_q;
    logic [31:0]        b_q;
    logic [31:0]        acc_q;
    op_t                op_q;
    logic [4:0]         rd_q;
    logic               accept;

    logic signed [LANE_W-1:0]   a_lane;
    logic signed [LANE_W-1:0]   b_lane;
    logic signed [2*LANE_W-1:0] prod;
    logic signed [31:0]         prod_ext;
    logic [LANE_W-1:0]          lane_res;
    logic [31:0]                work_d;
    int unsigned                lane_base;

    assign accept = start & ~flush & ((state_q == IDLE) | (state_q == DONE));

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        wb_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = EXEC;
            end
            EXEC: begin
                busy = 1'b1;
                if (cnt_q == LAST_LANE) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                wb_en   = 1'b1;
                state_d = start ? EXEC : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
        stall = busy | (start & ((state_q == IDLE) | (state_q == DONE)));
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // acc_q doubles as the lane-assembly register for the lane-wise ops
    // and as the running sum for PVMAC, so one datapath serves all four.
    always_comb begin
        lane_base = 32'(cnt_q) * LANE_W;
        a_lane    = a_q[lane_base +: LANE_W];
        b_lane    = b_q[lane_base +: LANE_W];
        prod      = (2*LANE_W)'(a_lane) * (2*LANE_W)'(b_lane);
        prod_ext  = 32'(prod);
        lane_res  = '0;
        work_d    = acc_q;
        unique case (op_q)
            OP_PVADD:       lane_res = a_lane + b_lane;
            OP_PVMUL:       lane_res = prod[LANE_W-1:0];
            OP_PVMUL_UPPER: lane_res = prod[2*LANE_W-1:LANE_W];
            default:        lane_res = '0;
        endcase
        if (op_q == OP_PVMAC) work_d = acc_q + prod_ext;
        else                  work_d[lane_base +: LANE_W] = lane_res;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            op_q   <= OP_PVADD;
            rd_q   <= '0;
            result <= '0;
            rd_out <= '0;
        end else if (accept) begin
            cnt_q <= '0;
            a_q   <= rs1_data;
            b_q   <= rs2_data;
            acc_q <= (vmac_ctrl == OP_PVMAC) ? acc_data : '0;
            op_q  <= op_t'(vmac_ctrl);
            rd_q  <= rd_in;
        end else if ((state_q == EXEC) && !flush) begin
            acc_q <= work_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_LANE) begin
                result <= work_d;
                rd_out <= rd_q;
            end
        end
    end

endmodule

// File: tb/tb_vmac_exec_unit.sv
// Scoreboard bench for vmac_exec_unit: directed cases plus randomized
// operations checked against a lane-arithmetic reference model.
module tb_vmac_exec_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  vmac_ctrl;
    logic [4:0]  rd_in;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] acc_data;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        wb_en;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
    } exp_t;
    exp_t sb[$];

    vmac_exec_unit #(.LANE_W(8), .NUM_LANES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .vmac_ctrl(vmac_ctrl),
        .rd_in(rd_in), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .acc_data(acc_data), .flush(flush), .stall(stall), .busy(busy),
        .done(done), .result(result), .rd_out(rd_out), .wb_en(wb_en)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: each lane as signed integers, plain arithmetic.
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] acc);
        logic [31:0] r;
        logic [7:0]  ab;
        logic [7:0]  bb;
        int          sa;
        int          sbv;
        int          p;
        r = (op == 2'b10) ? acc : 32'd0;
        for (int j = 0; j < 4; j++) begin
            ab  = a[j*8 +: 8];
            bb  = b[j*8 +: 8];
            sa  = int'($signed(ab));
            sbv = int'($signed(bb));
            p   = sa * sbv;
            case (op)
                2'b00:   r[j*8 +: 8] = 8'(sa + sbv);
                2'b01:   r[j*8 +: 8] = 8'(p);
                2'b11:   r[j*8 +: 8] = 8'(p >>> 8);
                default: r = r + 32'(p);
            endcase
        end
        return r;
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents a writeback.
    always @(negedge clk) begin
        if (!rst) begin
            chk("wb_en_eq_done", {31'b0, wb_en}, {31'b0, done});
            if (done === 1'b1) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_done: got done=1 result=0x%08h expected no writeback", result);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("result", result, e.res);
                    chk("rd_out", {27'b0, rd_out}, {27'b0, e.rd});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        rs1_data  = $urandom;
        rs2_data  = $urandom;
        acc_data  = $urandom;
        rd_in     = 5'($urandom);
        vmac_ctrl = 2'($urandom);
    endtask

    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] acc, input logic [4:0] rd,
                        input logic [31:0] exp_res, input bit push);
        start     = 1'b1;
        vmac_ctrl = op;
        rs1_data  = a;
        rs2_data  = b;
        acc_data  = acc;
        rd_in     = rd;
        #1;
        chk("stall_on_issue", {31'b0, stall}, 32'd1);
        if (push) sb.push_back('{exp_res, rd});
        tick();
        start = 1'b0;
        scramble();
    endtask

    task automatic wait_done(input string name, input int exp_n);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 12) begin
            tick();
            n++;
        end
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done after %0d cycles expected done", name, n);
        end else begin
            chk({name, "_latency"}, n, exp_n);
        end
    endtask

    task automatic chk_zero_outputs(input string name);
        chk({name, "_busy"},   {31'b0, busy},  32'd0);
        chk({name, "_done"},   {31'b0, done},  32'd0);
        chk({name, "_wb_en"},  {31'b0, wb_en}, 32'd0);
        chk({name, "_stall"},  {31'b0, stall}, 32'd0);
        chk({name, "_result"}, result,         32'd0);
        chk({name, "_rd_out"}, {27'b0, rd_out}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] acc;
        logic [1:0]  op;
        logic [4:0]  rd;
        int          dc0;

        rst = 1'b1; start = 1'b0; flush = 1'b0;
        vmac_ctrl = '0; rd_in = '0; rs1_data = '0; rs2_data = '0; acc_data = '0;
        repeat (3) tick();
        chk_zero_outputs("reset");
        rst = 1'b0;
        tick();

        // PVADD with cycle-accurate busy/stall/done profile
        send(2'b00, 32'h01FF7F80, 32'h01010101, 32'h0, 5'd5, 32'h02008081, 1'b1);
        for (int c = 0; c < 4; c++) begin
            chk("pvadd_busy",  {31'b0, busy},  32'd1);
            chk("pvadd_stall", {31'b0, stall}, 32'd1);
            chk("pvadd_early_done", {31'b0, done}, 32'd0);
            tick();
        end
        chk("pvadd_done", {31'b0, done}, 32'd1);
        chk("pvadd_busy_in_done", {31'b0, busy}, 32'd0);
        tick();
        chk("pvadd_done_one_cycle", {31'b0, done}, 32'd0);

        // PVMUL then back-to-back PVMUL_UPPER issued in DONE
        send(2'b01, 32'h02FF0380, 32'h03FF047F, 32'h0, 5'd7, 32'h06010C80, 1'b1);
        wait_done("pvmul", 4);
        send(2'b11, 32'h02FF0380, 32'h03FF047F, 32'h0, 5'd8, 32'h000000C0, 1'b1);
        wait_done("b2b_upper", 4);
        tick();

        send(2'b10, 32'h01020304, 32'h01010101, 32'h00000010, 5'd0, 32'h0000001A, 1'b1);
        wait_done("pvmac_small", 4);
        tick();
        send(2'b10, 32'h80808080, 32'h7F7F7F7F, 32'h0, 5'd31, 32'hFFFF0200, 1'b1);
        wait_done("pvmac_neg", 4);
        tick();

        // start pulsed during EXEC must be ignored
        dc0 = done_cnt;
        a = $urandom; b = $urandom;
        send(2'b00, a, b, 32'h0, 5'd9, model(2'b00, a, b, 32'h0), 1'b1);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("exec_start", 2);
        repeat (6) tick();
        chk("exec_start_done_count", done_cnt - dc0, 32'd1);

        // flush during lane 2
        dc0 = done_cnt;
        send(2'b01, $urandom, $urandom, 32'h0, 5'd3, 32'h0, 1'b0);
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_busy", {31'b0, busy}, 32'd0);
        chk("flush_done", {31'b0, done}, 32'd0);
        repeat (6) tick();
        chk("flush_done_count", done_cnt - dc0, 32'd0);

        // reset during lane 1
        send(2'b10, $urandom, $urandom, $urandom, 5'd12, 32'h0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        chk_zero_outputs("midrst");
        rst = 1'b0;
        tick();

        // flush and start together in IDLE
        dc0 = done_cnt;
        start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        chk("flush_start_busy", {31'b0, busy}, 32'd0);
        repeat (6) tick();
        chk("flush_start_done_count", done_cnt - dc0, 32'd0);

        for (int t = 0; t < 60; t++) begin
            op  = 2'($urandom_range(0, 3));
            a   = ($urandom_range(0, 3) == 0) ? 32'h80808080 : $urandom;
            b   = ($urandom_range(0, 3) == 0) ? 32'h7F7F7F7F : $urandom;
            acc = $urandom;
            rd  = 5'($urandom);
            send(op, a, b, acc, rd, model(op, a, b, acc), 1'b1);
            wait_done("random", 4);
            if ($urandom_range(0, 1) == 0) begin
                repeat ($urandom_range(1, 3)) tick();
            end
        end
        repeat (3) tick();
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vmac_exec_unit.md
Name: vmac_exec_unit

Overview:
- Execute-stage unit for the packed-SIMD VMAC extension (opcode 0x5B, funct3 001). Sits directly downstream of the combined decoder/control unit.
- Consumes is_vmac, vmac_ctrl and rd, plus register-file operands. Computes PVADD, PVMUL, PVMAC or PVMUL_UPPER over packed lanes using a single shared LANE_W x LANE_W signed multiplier, iterating one lane per cycle.
- Stalls the pipeline while busy and presents a one-cycle writeback result.

Parameters:
- LANE_W, 8, width of one packed lane in bits.
- NUM_LANES, 4, lanes per operand. LANE_W*NUM_LANES must equal 32.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  decoder's is_vmac qualified by a valid instruction in execute.
- vmac_ctrl  input  2  00 PVADD, 01 PVMUL, 10 PVMAC, 11 PVMUL_UPPER.
- rd_in  input  5  destination register index.
- rs1_data  input  32  packed operand A.
- rs2_data  input  32  packed operand B.
- acc_data  input  32  current value of rd; PVMAC accumulator.
- flush  input  1  abort the in-flight operation (branch or jump redirect).
- stall  output  1  hold upstream stages.
- busy  output  1  operation in progress (EXEC state).
- done  output  1  one-cycle pulse; result, rd_out and wb_en valid.
- result  output  32  writeback data.
- rd_out  output  5  writeback register index.
- wb_en  output  1  register-file write enable; equals done.

Behaviour:
- Reset: state IDLE. busy=0, done=0, wb_en=0, result=0, rd_out=0, lane counter=0, internal operand/accumulator registers=0.
- States:
  - IDLE: done=0, busy=0.
  - EXEC: busy=1; counter i runs 0..NUM_LANES-1.
  - DONE: done=1, wb_en=1, busy=0; lasts exactly one cycle.
- Transitions:
  - IDLE --start--> EXEC.
  - EXEC, i==NUM_LANES-1 --> DONE.
  - DONE --start--> EXEC (back-to-back accepted); otherwise DONE --> IDLE.
- Capture: at the accepting edge, latch rs1_data, rs2_data, acc_data, vmac_ctrl and rd_in, and clear the counter. Inputs may change afterwards.
- Start while in EXEC is ignored; the pipeline must not assert it because stall is high.
- stall = busy | (start & state is IDLE or DONE), so the issuing instruction is held.
- Latency: start sampled at edge k → lane j processed at edge k+1+j → done high during the cycle after edge k+NUM_LANES. That is 5 cycles start-to-done at default parameters.
- Lane j = bits [j*LANE_W +: LANE_W]. Lanes are processed LSB lane first. Products are signed LANE_W x LANE_W giving 2*LANE_W bits.
- Per-operation result:
  - PVADD: lane j = a_j + b_j mod 2^LANE_W.
  - PVMUL: lane j = product[LANE_W-1:0].
  - PVMUL_UPPER: lane j = product[2*LANE_W-1:LANE_W].
  - PVMAC: result = acc + sum over j of sext32(product_j), with 32-bit wrap and no saturation.
- result and rd_out hold their last values outside DONE; consumers must qualify with wb_en.
- flush: in any state, state goes to IDLE at the next edge. No done/wb_en for the aborted operation. busy=0 the following cycle.
- flush and start in the same cycle: flush wins and the start is not accepted.
- rst mid-operation: same as flush, and all outputs return to reset values.
- rd_in=0: the operation executes normally and wb_en still pulses; the register file discards writes to x0.

Test Plan:
- PVADD, a=0x01FF7F80, b=0x01010101 → result=0x02008081, rd_out=rd_in. done exactly 5 cycles after start; busy high for 4 cycles; stall high from the start cycle through the last EXEC cycle.
- PVMUL then PVMUL_UPPER, a=0x02FF0380, b=0x03FF047F → PVMUL result=0x06010C80; PVMUL_UPPER result=0x000000C0 (lane0 = -128*127 = 0xC080).
- PVMAC, acc=0x00000010, a=0x01020304, b=0x01010101 → 0x0000001A. PVMAC, acc=0, a=0x80808080, b=0x7F7F7F7F → 0xFFFF0200.
- Back-to-back: second start asserted in DONE with new operands is accepted, and its done arrives 5 cycles later. A start pulsed during EXEC yields no extra done.
- Operands change on the cycle after start → result still reflects the captured values.
- flush at EXEC lane 2 → no done; busy=0 next cycle. rst at lane 1 → all outputs zero next cycle. flush+start in the same cycle → stays IDLE.
